// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter.
//   rd_state_t          : read-channel FSM states
//   ICACHE_ID/DCACHE_ID : upstream read master indices
//   BYTE/HALF/WORD/LINE : AXI-style transfer type codes carried on *_type
package bus_arb_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } rd_state_t;

  localparam int ICACHE_ID = 0;
  localparam int DCACHE_ID = 1;

  localparam logic [2:0] BYTE = 3'b000;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] WORD = 3'b010;
  localparam logic [2:0] LINE = 3'b100;

endpackage

// File: rtl/bus_arb_wbuf.sv
// Single-entry write buffer between the DCache write port and the
// downstream write channel. Also exposes the buffered line address so the
// read arbiter can hold off reads that would overtake the pending write.
//   clk, rst          : clock, asynchronous active-low reset
//   wr_*              : upstream write request (wr_rdy out)
//   s_wr_*            : downstream write request (s_wr_rdy in)
//   wbuf_valid        : an entry is held
//   wbuf_line         : line address (addr[31:LINE_OFF_W]) of the held entry
module bus_arb_wbuf
  import bus_arb_pkg::*;
#(
  parameter int LINE_OFF_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [2:0]            wr_type,
  input  logic [31:0]           wr_addr,
  input  logic [15:0]           wr_wstrb,
  input  logic [127:0]          wr_data,
  output logic                  wr_rdy,
  output logic                  s_wr_req,
  output logic [2:0]            s_wr_type,
  output logic [31:0]           s_wr_addr,
  output logic [15:0]           s_wr_wstrb,
  output logic [127:0]          s_wr_data,
  input  logic                  s_wr_rdy,
  output logic                  wbuf_valid,
  output logic [31-LINE_OFF_W:0] wbuf_line
);

  logic         valid_q;
  logic [2:0]   type_q;
  logic [31:0]  addr_q;
  logic [15:0]  wstrb_q;
  logic [127:0] data_q;
  logic         accept;
  logic         drain;

  // Ready only when empty, so a draining entry blocks a same-cycle refill;
  // held low throughout reset.
  assign wr_rdy = rst & ~valid_q;
  assign accept = wr_req & wr_rdy;
  assign drain  = valid_q & s_wr_rdy;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

  // NOTE: the payload registers are deliberately not reset; valid_q
  // qualifies them and the outputs below are masked while empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      type_q  <= wr_type;
      addr_q  <= wr_addr;
      wstrb_q <= wr_wstrb;
      data_q  <= wr_data;
    end
  end

  assign s_wr_req   = valid_q;
  assign s_wr_type  = valid_q ? type_q  : '0;
  assign s_wr_addr  = valid_q ? addr_q  : '0;
  assign s_wr_wstrb = valid_q ? wstrb_q : '0;
  assign s_wr_data  = valid_q ? data_q  : '0;

  assign wbuf_valid = valid_q;
  assign wbuf_line  = addr_q[31:LINE_OFF_W];

endmodule

// File: rtl/bus_arbiter.sv
// Two-master read arbiter (ICache=0, DCache=1) plus a buffered DCache write
// path onto a single downstream bus. One downstream read is outstanding at
// a time; return beats are routed to the master that owns that read.
// Reads hitting the line held in the write buffer are stalled until the
// write drains.
//   clk, rst                         : clock, asynchronous active-low reset
//   m_rd_req/type/addr, m_rd_rdy     : upstream read requests per master
//   m_ret_valid/last, m_ret_data     : upstream return (data broadcast)
//   m_wr_*                           : DCache write port
//   s_rd_*, s_ret_*, s_wr_*          : downstream read, return, write
// Build option: define BUS_ARB_RR_EN for round-robin arbitration; otherwise
// DCache has fixed priority over ICache.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int LINE_OFF_W = 4,
  parameter int RD_PORTS   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RD_PORTS-1:0]      m_rd_req,
  input  logic [RD_PORTS-1:0][2:0] m_rd_type,
  input  logic [RD_PORTS-1:0][31:0] m_rd_addr,
  output logic [RD_PORTS-1:0]      m_rd_rdy,
  output logic [RD_PORTS-1:0]      m_ret_valid,
  output logic [RD_PORTS-1:0]      m_ret_last,
  output logic [127:0]             m_ret_data,
  input  logic                     m_wr_req,
  input  logic [2:0]               m_wr_type,
  input  logic [31:0]              m_wr_addr,
  input  logic [15:0]              m_wr_wstrb,
  input  logic [127:0]             m_wr_data,
  output logic                     m_wr_rdy,
  output logic                     s_rd_req,
  output logic [2:0]               s_rd_type,
  output logic [31:0]              s_rd_addr,
  input  logic                     s_rd_rdy,
  input  logic                     s_ret_valid,
  input  logic                     s_ret_last,
  input  logic [127:0]             s_ret_data,
  output logic                     s_wr_req,
  output logic [2:0]               s_wr_type,
  output logic [31:0]              s_wr_addr,
  output logic [15:0]              s_wr_wstrb,
  output logic [127:0]             s_wr_data,
  input  logic                     s_wr_rdy
);

  rd_state_t                 state;
  logic                      owner;
`ifdef BUS_ARB_RR_EN
  logic                      rr_ptr;
`endif
  logic                      wbuf_valid;
  logic [31-LINE_OFF_W:0]    wbuf_line;
  logic [RD_PORTS-1:0]       elig;
  logic                      winner;
  logic                      rd_issue;

  bus_arb_wbuf #(
    .LINE_OFF_W (LINE_OFF_W)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (m_wr_req),
    .wr_type    (m_wr_type),
    .wr_addr    (m_wr_addr),
    .wr_wstrb   (m_wr_wstrb),
    .wr_data    (m_wr_data),
    .wr_rdy     (m_wr_rdy),
    .s_wr_req   (s_wr_req),
    .s_wr_type  (s_wr_type),
    .s_wr_addr  (s_wr_addr),
    .s_wr_wstrb (s_wr_wstrb),
    .s_wr_data  (s_wr_data),
    .s_wr_rdy   (s_wr_rdy),
    .wbuf_valid (wbuf_valid),
    .wbuf_line  (wbuf_line)
  );

  // A master may compete only if its line is not sitting in the write
  // buffer; otherwise the read could return stale data.
  always_comb begin
    elig = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      elig[i] = m_rd_req[i] &
                ~(wbuf_valid && (m_rd_addr[i][31:LINE_OFF_W] == wbuf_line));
    end
  end

`ifdef BUS_ARB_RR_EN
  assign winner = elig[rr_ptr] ? rr_ptr : ~rr_ptr;
`else
  assign winner = elig[DCACHE_ID] ? 1'(DCACHE_ID) : 1'(ICACHE_ID);
`endif

  // Request side is silenced during reset so nothing leaks downstream.
  assign rd_issue = rst && (state == R_IDLE) && (|elig);

  // NOTE: every output of this block gets a default before the
  // conditional updates, so no latch can be inferred.
  always_comb begin
    s_rd_req    = rd_issue;
    s_rd_type   = '0;
    s_rd_addr   = '0;
    m_rd_rdy    = '0;
    m_ret_valid = '0;
    m_ret_last  = '0;
    if (rd_issue) begin
      s_rd_type        = m_rd_type[winner];
      s_rd_addr        = m_rd_addr[winner];
      m_rd_rdy[winner] = s_rd_rdy;
    end
    if (state == R_WAIT) begin
      m_ret_valid[owner] = s_ret_valid;
      m_ret_last[owner]  = s_ret_last;
    end
  end

  assign m_ret_data = rst ? s_ret_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= R_IDLE;
      owner  <= 1'b0;
`ifdef BUS_ARB_RR_EN
      rr_ptr <= 1'b0;
`endif
    end else begin
      case (state)
        R_IDLE: begin
          if (s_rd_req && s_rd_rdy) begin
            state  <= R_WAIT;
            owner  <= winner;
`ifdef BUS_ARB_RR_EN
            rr_ptr <= ~winner;
`endif
          end
        end
        R_WAIT: begin
          if (s_ret_valid && s_ret_last) begin
            state <= R_IDLE;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: table-driven arbitration vectors,
// read-owner and write scoreboards, and hand-written sequences for write
// drain, line hazard, reset during an outstanding read and contention.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       m_rd_req;
  logic [1:0][2:0]  m_rd_type;
  logic [1:0][31:0] m_rd_addr;
  logic [1:0]       m_rd_rdy;
  logic [1:0]       m_ret_valid;
  logic [1:0]       m_ret_last;
  logic [127:0]     m_ret_data;
  logic             m_wr_req;
  logic [2:0]       m_wr_type;
  logic [31:0]      m_wr_addr;
  logic [15:0]      m_wr_wstrb;
  logic [127:0]     m_wr_data;
  logic             m_wr_rdy;
  logic             s_rd_req;
  logic [2:0]       s_rd_type;
  logic [31:0]      s_rd_addr;
  logic             s_rd_rdy;
  logic             s_ret_valid;
  logic             s_ret_last;
  logic [127:0]     s_ret_data;
  logic             s_wr_req;
  logic [2:0]       s_wr_type;
  logic [31:0]      s_wr_addr;
  logic [15:0]      s_wr_wstrb;
  logic [127:0]     s_wr_data;
  logic             s_wr_rdy;

  bus_arbiter dut (
    .clk (clk), .rst (rst),
    .m_rd_req (m_rd_req), .m_rd_type (m_rd_type), .m_rd_addr (m_rd_addr),
    .m_rd_rdy (m_rd_rdy), .m_ret_valid (m_ret_valid), .m_ret_last (m_ret_last),
    .m_ret_data (m_ret_data),
    .m_wr_req (m_wr_req), .m_wr_type (m_wr_type), .m_wr_addr (m_wr_addr),
    .m_wr_wstrb (m_wr_wstrb), .m_wr_data (m_wr_data), .m_wr_rdy (m_wr_rdy),
    .s_rd_req (s_rd_req), .s_rd_type (s_rd_type), .s_rd_addr (s_rd_addr),
    .s_rd_rdy (s_rd_rdy),
    .s_ret_valid (s_ret_valid), .s_ret_last (s_ret_last), .s_ret_data (s_ret_data),
    .s_wr_req (s_wr_req), .s_wr_type (s_wr_type), .s_wr_addr (s_wr_addr),
    .s_wr_wstrb (s_wr_wstrb), .s_wr_data (s_wr_data), .s_wr_rdy (s_wr_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       rdy;
    logic [1:0] req_after;
    int         beats;
    logic       exp_req;
    logic       exp_owner;
    logic [1:0] exp_mrdy;
  } vec_t;

  typedef struct {
    logic [2:0]   typ;
    logic [31:0]  addr;
    logic [15:0]  wstrb;
    logic [127:0] data;
  } wr_t;

  vec_t vecs[7];
  int   rd_q[$];
  wr_t  wq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_rd_req = '0; m_rd_addr = '0;
    m_rd_type[0] = LINE; m_rd_type[1] = WORD;
    m_wr_req = 1'b0; m_wr_type = '0; m_wr_addr = '0; m_wr_wstrb = '0; m_wr_data = '0;
    s_rd_rdy = 1'b0; s_ret_valid = 1'b0; s_ret_last = 1'b0; s_ret_data = '0;
    s_wr_rdy = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Pops the expected owner and drives a return burst; then one idle cycle
  // with a stray beat that must be dropped.
  task automatic burst(input int beats, input logic [1:0] req_after,
                       input logic exp_idle_req, input logic [31:0] exp_next_addr);
    int owner;
    logic [1:0] ov;
    m_rd_req = req_after;
    s_rd_rdy = 1'b0;
    if (rd_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL rd_scoreboard: got empty queue expected an owner");
      owner = 0;
    end else begin
      owner = rd_q.pop_front();
    end
    ov = (owner == 1) ? 2'b10 : 2'b01;
    for (int b = 0; b < beats; b++) begin
      s_ret_valid = 1'b1;
      s_ret_last  = (b == beats - 1);
      s_ret_data  = rand128();
      @(negedge clk);
      check("ret_valid", m_ret_valid, ov);
      check("ret_last", m_ret_last, (b == beats - 1) ? ov : 2'b00);
      check("ret_data", m_ret_data, s_ret_data);
      check("wait_no_req", s_rd_req, 1'b0);
      check("wait_no_rdy", m_rd_rdy, 2'b00);
      next_cycle();
    end
    s_ret_valid = 1'b1;
    s_ret_last  = 1'b0;
    @(negedge clk);
    check("idle_stray_drop", m_ret_valid, 2'b00);
    check("idle_after_last", s_rd_req, exp_idle_req);
    if (exp_idle_req) check("idle_next_addr", s_rd_addr, exp_next_addr);
    s_ret_valid = 1'b0;
    next_cycle();
  endtask

  task automatic expect_wr_drain();
    wr_t e;
    if (wq.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL wr_scoreboard: got empty queue expected a write");
    end else begin
      e = wq.pop_front();
      check("s_wr_type", s_wr_type, e.typ);
      check("s_wr_addr", s_wr_addr, e.addr);
      check("s_wr_wstrb", s_wr_wstrb, e.wstrb);
      check("s_wr_data", s_wr_data, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d1, d2, d3;
    logic         exp_o;

    // ---------------- reset state ----------------
    clear_inputs();
    rst = 1'b0;
    m_rd_req = 2'b11; m_rd_addr[0] = 32'h1000; m_rd_addr[1] = 32'h2000;
    m_wr_req = 1'b1; m_wr_addr = 32'h5000; s_rd_rdy = 1'b1;
    s_ret_valid = 1'b1; s_ret_last = 1'b1; s_ret_data = rand128();
    @(negedge clk);
    check("rst_m_wr_rdy", m_wr_rdy, 1'b0);
    check("rst_s_rd_req", s_rd_req, 1'b0);
    check("rst_s_rd_addr", s_rd_addr, 32'h0);
    check("rst_m_rd_rdy", m_rd_rdy, 2'b00);
    check("rst_m_ret_valid", m_ret_valid, 2'b00);
    check("rst_m_ret_data", m_ret_data, 128'h0);
    check("rst_s_wr_req", s_wr_req, 1'b0);
    check("rst_s_wr_data", s_wr_data, 128'h0);
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rel_m_wr_rdy", m_wr_rdy, 1'b1);
    next_cycle();

    // ---------------- table-driven arbitration ----------------
    vecs[0] = '{req: 2'b00, rdy: 1'b1, req_after: 2'b00, beats: 0, exp_req: 1'b0, exp_owner: 1'b0, exp_mrdy: 2'b00};
    vecs[1] = '{req: 2'b01, rdy: 1'b0, req_after: 2'b00, beats: 0, exp_req: 1'b1, exp_owner: 1'b0, exp_mrdy: 2'b00};
    vecs[2] = '{req: 2'b10, rdy: 1'b0, req_after: 2'b00, beats: 0, exp_req: 1'b1, exp_owner: 1'b1, exp_mrdy: 2'b00};
`ifdef BUS_ARB_RR_EN
    vecs[3] = '{req: 2'b11, rdy: 1'b0, req_after: 2'b00, beats: 0, exp_req: 1'b1, exp_owner: 1'b0, exp_mrdy: 2'b00};
`else
    vecs[3] = '{req: 2'b11, rdy: 1'b0, req_after: 2'b00, beats: 0, exp_req: 1'b1, exp_owner: 1'b1, exp_mrdy: 2'b00};
`endif
    vecs[4] = '{req: 2'b01, rdy: 1'b1, req_after: 2'b00, beats: 1, exp_req: 1'b1, exp_owner: 1'b0, exp_mrdy: 2'b01};
    vecs[5] = '{req: 2'b11, rdy: 1'b1, req_after: 2'b01, beats: 4, exp_req: 1'b1, exp_owner: 1'b1, exp_mrdy: 2'b10};
    vecs[6] = '{req: 2'b10, rdy: 1'b1, req_after: 2'b00, beats: 2, exp_req: 1'b1, exp_owner: 1'b1, exp_mrdy: 2'b10};

    for (int i = 0; i < 7; i++) begin
      m_rd_req = vecs[i].req;
      m_rd_addr[0] = 32'h1000;
      m_rd_addr[1] = 32'h2000;
      s_rd_rdy = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_s_rd_req", i), s_rd_req, vecs[i].exp_req);
      check($sformatf("vec%0d_m_rd_rdy", i), m_rd_rdy, vecs[i].exp_mrdy);
      if (vecs[i].exp_req) begin
        check($sformatf("vec%0d_s_rd_addr", i), s_rd_addr,
              vecs[i].exp_owner ? 32'h2000 : 32'h1000);
        check($sformatf("vec%0d_s_rd_type", i), s_rd_type,
              vecs[i].exp_owner ? WORD : LINE);
      end
      if (vecs[i].rdy && vecs[i].exp_req) rd_q.push_back(int'(vecs[i].exp_owner));
      next_cycle();
      if (vecs[i].beats > 0)
        burst(vecs[i].beats, vecs[i].req_after, vecs[i].req_after != 2'b00,
              vecs[i].req_after[1] ? 32'h2000 : 32'h1000);
    end
    clear_inputs();
    next_cycle();

    // ---------------- write accept, drain, no refill in drain cycle ----------------
    d1 = rand128();
    d2 = rand128();
    s_wr_rdy = 1'b1;
    m_wr_req = 1'b1; m_wr_type = WORD; m_wr_addr = 32'h5000; m_wr_wstrb = 16'h00F0; m_wr_data = d1;
    @(negedge clk);
    check("wr1_m_wr_rdy", m_wr_rdy, 1'b1);
    check("wr1_s_wr_req_before", s_wr_req, 1'b0);
    wq.push_back('{typ: WORD, addr: 32'h5000, wstrb: 16'h00F0, data: d1});
    next_cycle();
    m_wr_addr = 32'h5010; m_wr_wstrb = 16'hFFFF; m_wr_data = d2;
    @(negedge clk);
    check("wr1_s_wr_req", s_wr_req, 1'b1);
    check("wr1_drain_rdy_low", m_wr_rdy, 1'b0);
    expect_wr_drain();
    next_cycle();
    @(negedge clk);
    check("wr1_s_wr_req_one_cycle", s_wr_req, 1'b0);
    check("wr1_rdy_after_drain", m_wr_rdy, 1'b1);
    wq.push_back('{typ: WORD, addr: 32'h5010, wstrb: 16'hFFFF, data: d2});
    next_cycle();
    m_wr_req = 1'b0;
    @(negedge clk);
    check("wr2_s_wr_req", s_wr_req, 1'b1);
    expect_wr_drain();
    next_cycle();
    @(negedge clk);
    check("wr2_empty", s_wr_req, 1'b0);
    next_cycle();

    // ---------------- read/write line hazard ----------------
    d3 = rand128();
    s_wr_rdy = 1'b0;
    m_wr_req = 1'b1; m_wr_type = WORD; m_wr_addr = 32'h3004; m_wr_wstrb = 16'h00F0; m_wr_data = d3;
    @(negedge clk);
    check("haz_wr_accept", m_wr_rdy, 1'b1);
    wq.push_back('{typ: WORD, addr: 32'h3004, wstrb: 16'h00F0, data: d3});
    next_cycle();
    m_wr_req = 1'b0;
    m_rd_req = 2'b01; m_rd_addr[0] = 32'h300C; m_rd_addr[1] = 32'h4000; s_rd_rdy = 1'b1;
    @(negedge clk);
    check("haz_blocked_req", s_rd_req, 1'b0);
    check("haz_blocked_rdy", m_rd_rdy, 2'b00);
    check("haz_wbuf_held", s_wr_req, 1'b1);
    next_cycle();
    m_rd_req = 2'b11;
    @(negedge clk);
    check("haz_other_req", s_rd_req, 1'b1);
    check("haz_other_addr", s_rd_addr, 32'h4000);
    check("haz_other_rdy", m_rd_rdy, 2'b10);
    rd_q.push_back(1);
    next_cycle();
    burst(1, 2'b01, 1'b0, 32'h0);
    s_wr_rdy = 1'b1; s_rd_rdy = 1'b1;
    @(negedge clk);
    check("haz_drain_req", s_wr_req, 1'b1);
    expect_wr_drain();
    check("haz_blocked_in_drain", s_rd_req, 1'b0);
    next_cycle();
    s_wr_rdy = 1'b0;
    @(negedge clk);
    check("haz_release_req", s_rd_req, 1'b1);
    check("haz_release_addr", s_rd_addr, 32'h300C);
    check("haz_release_rdy", m_rd_rdy, 2'b01);
    rd_q.push_back(0);
    next_cycle();
    burst(1, 2'b00, 1'b0, 32'h0);

    // ---------------- reset during R_WAIT ----------------
    m_rd_req = 2'b10; m_rd_addr[1] = 32'h6000; s_rd_rdy = 1'b1;
    @(negedge clk);
    check("rw_accept", m_rd_rdy, 2'b10);
    next_cycle();
    m_rd_req = 2'b00; s_rd_rdy = 1'b0; s_ret_valid = 1'b1; s_ret_last = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rw_rst_ret_valid", m_ret_valid, 2'b00);
    check("rw_rst_wr_rdy", m_wr_rdy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    m_rd_req = 2'b01; m_rd_addr[0] = 32'h7000; s_rd_rdy = 1'b1;
    #1;
    check("rw_rel_stray", m_ret_valid, 2'b00);
    check("rw_rel_req", s_rd_req, 1'b1);
    check("rw_rel_rdy", m_rd_rdy, 2'b01);
    check("rw_rel_addr", s_rd_addr, 32'h7000);
    rd_q.push_back(0);
    next_cycle();
    burst(1, 2'b00, 1'b0, 32'h0);

    // ---------------- four contended reads ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef BUS_ARB_RR_EN
      exp_o = (i % 2 == 1);
`else
      exp_o = 1'b1;
`endif
      m_rd_req = 2'b11; m_rd_addr[0] = 32'h1000; m_rd_addr[1] = 32'h2000; s_rd_rdy = 1'b1;
      @(negedge clk);
      check($sformatf("cont%0d_addr", i), s_rd_addr, exp_o ? 32'h2000 : 32'h1000);
      check($sformatf("cont%0d_rdy", i), m_rd_rdy, exp_o ? 2'b10 : 2'b01);
      rd_q.push_back(int'(exp_o));
      next_cycle();
`ifdef BUS_ARB_RR_EN
      burst(1, 2'b11, 1'b1, exp_o ? 32'h1000 : 32'h2000);
`else
      burst(1, 2'b11, 1'b1, 32'h2000);
`endif
    end
    clear_inputs();
    next_cycle();
    check("rd_scoreboard_empty", 32'(rd_q.size()), 32'd0);
    check("wr_scoreboard_empty", 32'(wq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter LINE_OFF_W, default 4, number of byte-offset bits in a cache line (16 B lines) used for hazard compare.
REQ-002 Parameter RD_PORTS, default 2, number of upstream read masters; index 0 is ICache, index 1 is DCache; only 2 is supported.
REQ-003 Port clk, in, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst, in, 1, asynchronous active-low reset.
REQ-005 Port m_rd_req, in, 2, per-master read request valid.
REQ-006 Ports m_rd_type and m_rd_addr, in, 2x3 and 2x32, per-master read type and start address.
REQ-007 Port m_rd_rdy, out, 2, per-master read accepted this cycle.
REQ-008 Ports m_ret_valid and m_ret_last, out, 2 each, per-master return beat valid and last beat.
REQ-009 Port m_ret_data, out, 128, shared return data broadcast to both masters.
REQ-010 Ports m_wr_req in 1, m_wr_type in 3, m_wr_addr in 32, m_wr_wstrb in 16, m_wr_data in 128, m_wr_rdy out 1: DCache write port.
REQ-011 Ports s_rd_req out 1, s_rd_type out 3, s_rd_addr out 32, s_rd_rdy in 1: downstream read request.
REQ-012 Ports s_ret_valid in 1, s_ret_last in 1, s_ret_data in 128: downstream read return.
REQ-013 Ports s_wr_req out 1, s_wr_type out 3, s_wr_addr out 32, s_wr_wstrb out 16, s_wr_data out 128, s_wr_rdy in 1: downstream write.

Function
REQ-014 Read FSM SHALL have states R_IDLE and R_WAIT, with at most one downstream read outstanding.
REQ-015 In R_IDLE, the winner SHALL be chosen combinationally among requesting masters not blocked by hazard (REQ-020).
REQ-016 s_rd_req, s_rd_type and s_rd_addr SHALL equal the winner's signals; m_rd_rdy[winner] = s_rd_rdy; all other m_rd_rdy = 0.
REQ-017 On s_rd_req && s_rd_rdy, the FSM SHALL register the winner as owner and move to R_WAIT.
REQ-018 In R_WAIT, s_rd_req = 0 and m_rd_rdy = 0; s_ret_valid/s_ret_last SHALL route only to owner; on s_ret_valid && s_ret_last, the FSM SHALL return to R_IDLE next cycle.
REQ-019 In R_IDLE, m_ret_valid and m_ret_last SHALL be 0 regardless of s_ret_valid; stray beats are dropped.
REQ-020 Write buffer: one entry; m_wr_rdy = !wbuf_valid; m_wr_req && m_wr_rdy latches all write fields and sets wbuf_valid.
REQ-021 s_wr_req = wbuf_valid, driving buffered fields; s_wr_req && s_wr_rdy clears wbuf_valid.
REQ-022 The buffer SHALL NOT accept a new write in the cycle it drains; the earliest next accept is the cycle after.
REQ-023 Hazard: a read with addr[31:LINE_OFF_W] equal to the buffered write line while wbuf_valid SHALL be blocked; the other master may still win.
REQ-024 Read and write channels SHALL operate concurrently and independently apart from REQ-023.

Reset
REQ-025 On rst low, the design SHALL asynchronously reset to R_IDLE, owner = 0, wbuf_valid = 0, rr_ptr = 0.
REQ-026 During reset, all outputs SHALL be 0 except m_wr_rdy, which is 0 while rst is low and 1 after release.
REQ-027 Reset during R_WAIT SHALL abandon the outstanding read; later downstream beats fall under REQ-019.

Configuration
REQ-028 With BUS_ARB_RR_EN defined: round-robin arbitration; rr_ptr names the preferred master and SHALL toggle to the non-winner on each accepted read.
REQ-029 Without BUS_ARB_RR_EN: fixed priority, with DCache (1) over ICache (0); rr_ptr is not implemented.

Structure
REQ-030 Package bus_arb_pkg SHALL hold the rd_state_t enum, the master index constants ICACHE_ID=0 and DCACHE_ID=1, and the AXI type codes (BYTE=000, HALF=001, WORD=010, LINE=100).
REQ-031 One sub-module, bus_arb_wbuf, SHALL implement the write buffer and expose wbuf_valid and the buffered line address for hazard compare.

Verification
REQ-032 Fixed priority: both masters request 0x1000/0x2000 in the same cycle with s_rd_rdy=1 -> s_rd_addr=0x2000, m_rd_rdy=2'b10; ICache is issued after DCache's last beat.
REQ-033 BUS_ARB_RR_EN: 4 back-to-back contended reads -> grant order 0,1,0,1.
REQ-034 Burst of 4 beats with s_ret_last on beat 4 -> owner sees m_ret_valid for 4 cycles, the other master sees 0, and the FSM is in R_IDLE the cycle after the last beat.
REQ-035 Write 0x3004 buffered with s_wr_rdy=0 and ICache reads 0x300C -> read blocked; DCache read 0x4000 still granted; after s_wr_rdy, 0x300C issues.
REQ-036 rst asserted mid-R_WAIT, then s_ret_valid=1 after release -> m_ret_valid=0, and a new read is accepted in the first cycle after release.
REQ-037 Write accepted with s_wr_rdy=1 -> s_wr_req high for one cycle, m_wr_rdy low that cycle and high the next.
